uart_8n1_rx_buffer: RTL and testbench

Downstream companion of the 8N1 receiver: the receive-side controller plus the byte FIFO behind it. It drives the receiver's read handshake to arm one frame at a time and re-arms immediately after each frame, so back-to-back frames are accepted. Good bytes are pushed into a first-word-fall-through FIFO; errored frames are counted and dropped. It sits between the receiver and the host/bus-side consumer. Everything runs in the 16x baud clock domain.

---
 rtl/uart_8n1_rx_buffer.sv | 139 +++++++++++++
 tb/tb_uart_8n1_rx_buffer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_8n1_rx_buffer.sv
// Receive-side controller for the 8N1 receiver plus the first-word-fall-through byte FIFO.
// Arms one frame at a time, stores good bytes, and counts and drops errored frames.
module uart_8n1_rx_buffer #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_baud_16x,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [7:0]            recv_data,
    input  logic                  recv_busy,
    input  logic                  recv_error,
    output logic                  recv_read,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    input  logic                  rd_pop,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overrun,
    output logic                  frame_error,
    output logic [7:0]            error_count,
    input  logic                  clear_status
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LevelFull = (DEPTH_LOG2 + 1)'(Depth);

    typedef enum logic [1:0] {StIdle, StArm, StRecv} state_t;

    state_t state_q, state_d;

    logic [7:0]            mem [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_error_q, frame_error_d;
    logic [7:0]            error_count_q, error_count_d;

    logic commit, full, pop_ok, push, err_set, overrun_set;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: if (enable) state_d = StArm;
            // A busy receiver means the frame is already in flight, so it beats enable=0.
            StArm: begin
                if (recv_busy) begin
                    state_d = StRecv;
                end else if (!enable) begin
                    state_d = StIdle;
                end
            end
            StRecv: begin
                if (!recv_busy) begin
                    commit  = 1'b1;
                    state_d = enable ? StArm : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign recv_read = (state_q == StArm);

    assign full        = (level_q == LevelFull);
    assign pop_ok      = rd_pop && (level_q != '0);
    assign err_set     = commit && recv_error;
    assign overrun_set = commit && !recv_error && full && !pop_ok;
    assign push        = commit && !recv_error && (!full || pop_ok);

    always_comb begin
        level_d = level_q;
        if (push && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    // A setting event in the same cycle as clear_status wins over the clear.
    always_comb begin
        overrun_d     = overrun_q;
        frame_error_d = frame_error_q;
        error_count_d = error_count_q;
        if (clear_status) begin
            overrun_d     = 1'b0;
            frame_error_d = 1'b0;
            error_count_d = 8'd0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
        if (err_set) begin
            frame_error_d = 1'b1;
            if (clear_status) begin
                error_count_d = 8'd1;
            end else if (error_count_q != 8'hFF) begin
                error_count_d = error_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_baud_16x) begin
        if (reset) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
            error_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
            error_count_q <= error_count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_baud_16x) begin
        if (push && !reset) begin
            mem[wr_ptr_q] <= recv_data;
        end
    end

    assign rd_valid    = (level_q != '0);
    assign rd_data     = rd_valid ? mem[rd_ptr_q] : 8'd0;
    assign level       = level_q;
    assign overrun     = overrun_q;
    assign frame_error = frame_error_q;
    assign error_count = error_count_q;

endmodule

// File: tb/tb_uart_8n1_rx_buffer.sv
// Bench for uart_8n1_rx_buffer: a behavioural receiver delivers queued frames on arm,
// and a byte scoreboard checks what comes out of the FIFO.
module tb_uart_8n1_rx_buffer;

    localparam int unsigned DEPTH_LOG2  = 4;
    localparam int unsigned FRAME_TICKS = 20;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } frame_t;

    logic                clk_baud_16x = 1'b0;
    logic                reset        = 1'b1;
    logic                enable       = 1'b0;
    logic                rd_pop       = 1'b0;
    logic                clear_status = 1'b0;
    logic [7:0]          recv_data    = 8'd0;
    logic                recv_busy    = 1'b0;
    logic                recv_error   = 1'b0;
    logic                recv_read;
    logic [7:0]          rd_data;
    logic                rd_valid;
    logic [DEPTH_LOG2:0] level;
    logic                overrun;
    logic                frame_error;
    logic [7:0]          error_count;

    frame_t      frame_q [$];
    logic [7:0]  exp_q [$];
    int unsigned rx_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    uart_8n1_rx_buffer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk_baud_16x (clk_baud_16x),
        .reset        (reset),
        .enable       (enable),
        .recv_data    (recv_data),
        .recv_busy    (recv_busy),
        .recv_error   (recv_error),
        .recv_read    (recv_read),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_pop       (rd_pop),
        .level        (level),
        .overrun      (overrun),
        .frame_error  (frame_error),
        .error_count  (error_count),
        .clear_status (clear_status)
    );

    always #5 clk_baud_16x = ~clk_baud_16x;

    // Receiver model: a read arms it (busy, stale error cleared); while armed it waits for a
    // queued frame, spends FRAME_TICKS on it, then drops busy with data/error valid.
    always @(posedge clk_baud_16x) begin
        if (reset) begin
            if (recv_busy && rx_cnt != 0) void'(frame_q.pop_front());
            recv_busy  <= 1'b0;
            recv_error <= 1'b0;
            rx_cnt     <= 0;
        end else if (!recv_busy) begin
            if (recv_read) begin
                recv_busy  <= 1'b1;
                recv_error <= 1'b0;
                rx_cnt     <= 0;
            end
        end else if (frame_q.size() != 0) begin
            if (rx_cnt == FRAME_TICKS - 1) begin
                recv_busy  <= 1'b0;
                recv_data  <= frame_q[0].data;
                recv_error <= frame_q[0].err;
                rx_cnt     <= 0;
                void'(frame_q.pop_front());
            end else begin
                rx_cnt <= rx_cnt + 1;
            end
        end
    end

    task automatic send_frame(input logic [7:0] data, input logic err);
        frame_t f;
        f.data = data;
        f.err  = err;
        frame_q.push_back(f);
    endtask

    // Returns at the negedge right after the edge where busy fell, plus extra cycles.
    task automatic wait_commit(input string name, input int unsigned extra);
        int unsigned n = 0;
        while (frame_q.size() != 0 && n < 10000) begin
            @(negedge clk_baud_16x);
            n++;
        end
        if (frame_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d frames pending, required 0", name, frame_q.size());
            frame_q.delete();
        end
        repeat (extra) @(negedge clk_baud_16x);
    endtask

    task automatic pop_one(output logic valid, output logic [7:0] data);
        valid  = rd_valid;
        data   = rd_data;
        rd_pop = 1'b1;
        @(negedge clk_baud_16x);
        rd_pop = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk_baud_16x);
        checks++; if (recv_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b exp 0", recv_read); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rd_valid); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_error); end
        checks++; if (error_count !== 8'd0) begin errors++; $display("FAIL reset_ecnt got %0d exp 0", error_count); end
        reset  = 1'b0;
        enable = 1'b1;
        repeat (5) @(negedge clk_baud_16x);
    endtask

    task automatic test_single();
        logic v;
        logic [7:0] d, e;
        send_frame(8'hA5, 1'b0);
        exp_q.push_back(8'hA5);
        wait_commit("single", 0);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", rd_valid); end
        @(negedge clk_baud_16x);
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rd_valid); end
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", rd_data); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level got %0d exp 1", level); end
        checks++; if (recv_read !== 1'b1) begin errors++; $display("FAIL single_rearm got %b exp 1", recv_read); end
        @(negedge clk_baud_16x);
        checks++; if (recv_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", recv_busy); end
        @(negedge clk_baud_16x);
        checks++; if (recv_read !== 1'b0) begin errors++; $display("FAIL single_recv got %b exp 0", recv_read); end
        pop_one(v, d);
        e = exp_q.pop_front();
        checks++; if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL single_pop got %b/%h exp 1/%h", v, d, e); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL single_empty got %0d exp 0", level); end
    endtask

    task automatic test_back_to_back();
        logic v;
        logic [7:0] d, e;
        for (int i = 0; i < 17; i++) begin
            send_frame(i[7:0], 1'b0);
            if (i < 16) exp_q.push_back(i[7:0]);
        end
        wait_commit("b2b", 3);
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL b2b_level got %0d exp 16", level); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b exp 1", overrun); end
        checks++; if (error_count !== 8'd0) begin errors++; $display("FAIL b2b_ecnt got %0d exp 0", error_count); end
        for (int i = 0; i < 16; i++) begin
            pop_one(v, d);
            e = exp_q.pop_front();
            checks++; if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL b2b_pop%0d got %b/%h exp 1/%h", i, v, d, e); end
        end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", rd_valid); end
        clear_status = 1'b1;
        @(negedge clk_baud_16x);
        clear_status = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_clear got %b exp 0", overrun); end
    endtask

    task automatic test_frame_error();
        logic v;
        logic [7:0] d, e;
        send_frame(8'h3C, 1'b1);
        send_frame(8'h5A, 1'b0);
        exp_q.push_back(8'h5A);
        wait_commit("ferr", 3);
        checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b exp 1", frame_error); end
        checks++; if (error_count !== 8'd1) begin errors++; $display("FAIL ferr_ecnt got %0d exp 1", error_count); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL ferr_level got %0d exp 1", level); end
        pop_one(v, d);
        e = exp_q.pop_front();
        checks++; if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL ferr_pop got %b/%h exp 1/%h", v, d, e); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ferr_drained got %b exp 0", rd_valid); end
        clear_status = 1'b1;
        @(negedge clk_baud_16x);
        clear_status = 1'b0;
        checks++; if (frame_error !== 1'b0 || error_count !== 8'd0) begin
            errors++; $display("FAIL ferr_clear got %b/%0d exp 0/0", frame_error, error_count);
        end
    endtask

    task automatic test_pop_on_full();
        logic v;
        logic [7:0] d, e;
        for (int i = 0; i < 16; i++) begin
            send_frame(8'h10 + i[7:0], 1'b0);
            exp_q.push_back(8'h10 + i[7:0]);
        end
        wait_commit("pfull_fill", 3);
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL pfull_level got %0d exp 16", level); end
        send_frame(8'h77, 1'b0);
        exp_q.push_back(8'h77);
        wait_commit("pfull_commit", 0);
        // The pop lands on the same edge as the commit of 0x77.
        pop_one(v, d);
        e = exp_q.pop_front();
        checks++; if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL pfull_head got %b/%h exp 1/%h", v, d, e); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL pfull_keep got %0d exp 16", level); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL pfull_overrun got %b exp 0", overrun); end
        for (int i = 0; i < 16; i++) begin
            pop_one(v, d);
            e = exp_q.pop_front();
            checks++; if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL pfull_pop%0d got %b/%h exp 1/%h", i, v, d, e); end
        end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL pfull_drained got %b exp 0", rd_valid); end
    endtask

    task automatic test_enable_drop();
        send_frame(8'h81, 1'b0);
        exp_q.push_back(8'h81);
        repeat (FRAME_TICKS / 2) @(negedge clk_baud_16x);
        enable = 1'b0;
        wait_commit("endrop", 4);
        checks++; if (level !== 5'd1 || rd_data !== exp_q[0]) begin
            errors++; $display("FAIL endrop_store got %0d/%h exp 1/%h", level, rd_data, exp_q[0]);
        end
        checks++; if (recv_read !== 1'b0) begin errors++; $display("FAIL endrop_read got %b exp 0", recv_read); end
        checks++; if (recv_busy !== 1'b0) begin errors++; $display("FAIL endrop_idle got %b exp 0", recv_busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic v;
        logic [7:0] d, e;
        int unsigned n = 0;
        enable = 1'b1;
        send_frame(8'hEE, 1'b1);
        wait_commit("rstmid_err", 3);
        checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b exp 1", frame_error); end
        send_frame(8'h99, 1'b0);
        while (rx_cnt < 8 && n < 100) begin
            @(negedge clk_baud_16x);
            n++;
        end
        reset = 1'b1;
        @(negedge clk_baud_16x);
        reset = 1'b0;
        exp_q.delete();
        checks++; if ({recv_read, rd_valid, rd_data, level, overrun, frame_error, error_count} !== '0) begin
            errors++;
            $display("FAIL rstmid_zero got read=%b valid=%b data=%h level=%0d ovr=%b ferr=%b ecnt=%0d exp all 0",
                     recv_read, rd_valid, rd_data, level, overrun, frame_error, error_count);
        end
        send_frame(8'h42, 1'b0);
        exp_q.push_back(8'h42);
        wait_commit("rstmid_next", 3);
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL rstmid_level got %0d exp 1", level); end
        pop_one(v, d);
        e = exp_q.pop_front();
        checks++; if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL rstmid_pop got %b/%h exp 1/%h", v, d, e); end
    endtask

    task automatic test_error_saturate();
        for (int i = 0; i < 256; i++) send_frame(i[7:0], 1'b1);
        wait_commit("sat", 3);
        checks++; if (error_count !== 8'd255) begin errors++; $display("FAIL sat_ecnt got %0d exp 255", error_count); end
        checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL sat_flag got %b exp 1", frame_error); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL sat_level got %0d exp 0", level); end
        send_frame(8'hAB, 1'b1);
        wait_commit("sat_clear", 0);
        clear_status = 1'b1;
        @(negedge clk_baud_16x);
        clear_status = 1'b0;
        checks++; if (error_count !== 8'd1) begin errors++; $display("FAIL satclr_ecnt got %0d exp 1", error_count); end
        checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL satclr_flag got %b exp 1", frame_error); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_error();
        test_pop_on_full();
        test_enable_drop();
        test_reset_mid_frame();
        test_error_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
